seq_pattern_tx: RTL and testbench

Serial pattern transmitter, the source-side counterpart of the 1011 sequence detector. It accepts a parallel pattern word plus a repeat count and gap length through a valid/ready start handshake. It then emits the pattern MSB-first as a one-bit stream, with optional idle-zero gaps between frames. It drives the detector's serial input in system and in benches, and reports frame progress and completion.

---
 rtl/seq_pattern_tx_pkg.sv | 15 +
 rtl/seq_pattern_tx_if.sv | 28 ++
 rtl/seq_pattern_tx_shreg.sv | 46 ++++
 rtl/seq_pattern_tx.sv | 159 +++++++++++++++
 tb/tb_seq_pattern_tx.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Parity framing is selected by SEQ_PATTERN_TX_PARITY_EN (see seq_pattern_tx.sv).
package seq_pattern_tx_pkg;

    // 3-bit encoding kept aligned with the 1011 detector's state register
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        PARITY = 3'd2,
        GAP    = 3'd3
    } state_e;

    localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Start handshake and serial stream bundle for seq_pattern_tx.
// The slave modport is the transmitter, the master modport its user.
interface seq_pattern_tx_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP_W = 4
) ();
    logic             start_valid;
    logic             start_ready;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             out_bit;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frames_sent;

    modport master (
        output start_valid, pattern, repeat_cnt, gap_len,
        input  start_ready, out_bit, out_valid, busy, done, frames_sent
    );

    modport slave (
        input  start_valid, pattern, repeat_cnt, gap_len,
        output start_ready, out_bit, out_valid, busy, done, frames_sent
    );
endinterface

// File: rtl/seq_pattern_tx_shreg.sv
// Loadable MSB-first shift register with a last-bit flag.
// Holds only the bits after the one currently on the line; the caller emits the MSB on load.
module seq_pattern_tx_shreg
    import seq_pattern_tx_pkg::*;
#(
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-2:0] data_in,
    output logic             next_bit,
    output logic             last_bit
);
    localparam int unsigned IDX_W = $clog2(PAT_W);

    logic [PAT_W-2:0] sr_q, sr_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (load) begin
            sr_d  = data_in;
            idx_d = '0;
        end else if (shift) begin
            sr_d  = sr_q << 1;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    assign next_bit = sr_q[PAT_W-2];
    assign last_bit = (idx_q == IDX_W'(PAT_W - 1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: repeats a latched pattern MSB-first with optional idle gaps.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit to every frame.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    seq_pattern_tx_if.slave  bus
);
    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;

    logic             sr_load, sr_shift, frame_end;
    logic             next_bit, last_bit;
    logic [PAT_W-1:0] ld_data;

    // In IDLE the register loads straight from the port; later frames reload the latched copy
    assign ld_data = (state_q == IDLE) ? bus.pattern : pat_q;

    seq_pattern_tx_shreg #(
        .PAT_W (PAT_W)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (sr_load),
        .shift    (sr_shift),
        .data_in  (ld_data[PAT_W-2:0]),
        .next_bit (next_bit),
        .last_bit (last_bit)
    );

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        rep_d       = rep_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        frames_d    = frames_q;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        frame_end   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    pat_d     = bus.pattern;
                    rep_d     = bus.repeat_cnt;
                    gap_len_d = bus.gap_len;
                    frames_d  = '0;
                    if (bus.repeat_cnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = SHIFT;
                        sr_load     = 1'b1;
                        out_bit_d   = bus.pattern[PAT_W-1];
                        out_valid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sr_shift    = 1'b1;
                    out_bit_d   = next_bit;
                    out_valid_d = 1'b1;
                end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    state_d     = PARITY;
                    out_bit_d   = ^pat_q;
                    out_valid_d = 1'b1;
`else
                    frame_end   = 1'b1;
`endif
                end
            end
`ifdef SEQ_PATTERN_TX_PARITY_EN
            PARITY: begin
                frame_end = 1'b1;
            end
`endif
            GAP: begin
                out_valid_d = 1'b1;
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = SHIFT;
                    sr_load   = 1'b1;
                    out_bit_d = pat_q[PAT_W-1];
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared frame-completion path for the LSB cycle and the parity cycle
        if (frame_end) begin
            frames_d = frames_q + CNT_W'(1);
            if (frames_d == rep_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (gap_len_q == '0) begin
                state_d     = SHIFT;
                sr_load     = 1'b1;
                out_bit_d   = pat_q[PAT_W-1];
                out_valid_d = 1'b1;
            end else begin
                state_d     = GAP;
                gap_cnt_d   = gap_len_q;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            rep_q       <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            frames_q    <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            rep_q       <= rep_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            frames_q    <= frames_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.out_bit     = out_bit_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.done        = done_q;
    assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx; expected streams follow SEQ_PATTERN_TX_PARITY_EN.
module tb_seq_pattern_tx;
    import seq_pattern_tx_pkg::*;

`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam logic [31:0] S_T1  = 32'b1011110111;
    localparam int unsigned L_T1  = 10;
    localparam logic [31:0] S_T2  = 32'b101110010111;
    localparam int unsigned L_T2  = 12;
    localparam logic [31:0] S_T4A = 32'b10111;
    localparam int unsigned L_T4A = 5;
    localparam logic [31:0] S_T4B = 32'b01100;
    localparam int unsigned L_T4B = 5;
    localparam logic [31:0] S_T6  = 32'b10010;
    localparam int unsigned L_T6  = 5;
`else
    localparam logic [31:0] S_T1  = 32'b10111011;
    localparam int unsigned L_T1  = 8;
    localparam logic [31:0] S_T2  = 32'b1011001011;
    localparam int unsigned L_T2  = 10;
    localparam logic [31:0] S_T4A = 32'b1011;
    localparam int unsigned L_T4A = 4;
    localparam logic [31:0] S_T4B = 32'b0110;
    localparam int unsigned L_T4B = 4;
    localparam logic [31:0] S_T6  = 32'b1001;
    localparam int unsigned L_T6  = 4;
`endif

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_mis;
    logic [3:0] win;
    int   n_bits;
    int   seen;

    seq_pattern_tx_if #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) bus ();

    seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference 1011 detector fed from the observed stream
    task automatic observe_bit(input logic b);
        win = {win[2:0], b};
        n_bits++;
        if (n_bits >= 4 && win == PAT_1011) seen++;
    endtask

    task automatic run_tx(input string tag, input logic [3:0] pat, input logic [7:0] rep,
                          input logic [3:0] gap, input logic [31:0] stream,
                          input int unsigned len, input int exp_seen);
        win    = '0;
        n_bits = 0;
        seen   = 0;
        bus.pattern     = pat;
        bus.repeat_cnt  = rep;
        bus.gap_len     = gap;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        bus.pattern     = ~pat;
        bus.repeat_cnt  = rep + 8'd3;
        bus.gap_len     = gap + 4'd1;
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        chk({tag, ".ready_busy"}, 32'(bus.start_ready), 32'd0);
        for (int unsigned i = 0; i < len; i++) begin
            chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, ".bit"}, 32'(bus.out_bit), 32'(stream[len-1-i]));
            chk({tag, ".done_early"}, 32'(bus.done), 32'd0);
            observe_bit(bus.out_bit);
            tick();
        end
        chk({tag, ".done"}, 32'(bus.done), 32'd1);
        chk({tag, ".valid_end"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".bit_end"}, 32'(bus.out_bit), 32'd0);
        chk({tag, ".ready_end"}, 32'(bus.start_ready), 32'd1);
        chk({tag, ".frames"}, 32'(bus.frames_sent), 32'(rep));
        chk({tag, ".seen"}, 32'(seen), 32'(exp_seen));
        tick();
        chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, ".frames_hold"}, 32'(bus.frames_sent), 32'(rep));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b1;
        bus.start_valid = 1'b0;
        bus.pattern     = '0;
        bus.repeat_cnt  = '0;
        bus.gap_len     = '0;
        tick();
        tick();
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.bit", 32'(bus.out_bit), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.frames", 32'(bus.frames_sent), 32'd0);
        chk("rst.ready", 32'(bus.start_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Back-to-back frames, then frames separated by a two-bit gap
        run_tx("t1", 4'b1011, 8'd2, 4'd0, S_T1, L_T1, 2);
        run_tx("t2", 4'b1011, 8'd2, 4'd2, S_T2, L_T2, 2);

        // Zero repeat count completes without emitting anything
        bus.pattern     = 4'b1011;
        bus.repeat_cnt  = 8'd0;
        bus.gap_len     = 4'd1;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        chk("t3.done", 32'(bus.done), 32'd1);
        chk("t3.valid", 32'(bus.out_valid), 32'd0);
        chk("t3.frames", 32'(bus.frames_sent), 32'd0);
        chk("t3.ready", 32'(bus.start_ready), 32'd1);
        chk("t3.busy", 32'(bus.busy), 32'd0);
        tick();
        chk("t3.done_pulse", 32'(bus.done), 32'd0);
        chk("t3.valid2", 32'(bus.out_valid), 32'd0);

        // start_valid held through a busy transmission is taken only in the done cycle
        bus.pattern     = 4'b1011;
        bus.repeat_cnt  = 8'd1;
        bus.gap_len     = 4'd0;
        bus.start_valid = 1'b1;
        tick();
        bus.pattern = 4'b0110;
        for (int unsigned i = 0; i < L_T4A; i++) begin
            chk("t4a.valid", 32'(bus.out_valid), 32'd1);
            chk("t4a.bit", 32'(bus.out_bit), 32'(S_T4A[L_T4A-1-i]));
            chk("t4a.busy", 32'(bus.busy), 32'd1);
            tick();
        end
        chk("t4a.done", 32'(bus.done), 32'd1);
        chk("t4a.ready", 32'(bus.start_ready), 32'd1);
        chk("t4a.frames", 32'(bus.frames_sent), 32'd1);
        tick();
        bus.start_valid = 1'b0;
        chk("t4b.frames_clr", 32'(bus.frames_sent), 32'd0);
        chk("t4b.busy", 32'(bus.busy), 32'd1);
        for (int unsigned i = 0; i < L_T4B; i++) begin
            chk("t4b.valid", 32'(bus.out_valid), 32'd1);
            chk("t4b.bit", 32'(bus.out_bit), 32'(S_T4B[L_T4B-1-i]));
            tick();
        end
        chk("t4b.done", 32'(bus.done), 32'd1);
        chk("t4b.frames", 32'(bus.frames_sent), 32'd1);
        tick();

        // Reset during the third bit of the first frame aborts silently
        bus.pattern     = 4'b1011;
        bus.repeat_cnt  = 8'd2;
        bus.gap_len     = 4'd0;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        tick();
        tick();
        chk("t5.bit3", 32'(bus.out_bit), 32'd1);
        chk("t5.valid3", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5.valid", 32'(bus.out_valid), 32'd0);
        chk("t5.bit", 32'(bus.out_bit), 32'd0);
        chk("t5.busy", 32'(bus.busy), 32'd0);
        chk("t5.frames", 32'(bus.frames_sent), 32'd0);
        chk("t5.ready", 32'(bus.start_ready), 32'd1);
        chk("t5.done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5.no_done", 32'(bus.done), 32'd0);
            chk("t5.idle_valid", 32'(bus.out_valid), 32'd0);
        end

        // Pattern with zero parity
        run_tx("t6", 4'b1001, 8'd1, 4'd0, S_T6, L_T6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
